// File: rtl/operand_forward_unit_pkg.sv
// Shared constants and the load-use FSM state type for the operand forwarding unit.
package operand_forward_unit_pkg;

    localparam int FWD_SEL_RF = 0;
    localparam int REG_X0     = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } fsm_state_e;

endpackage

// File: rtl/operand_forward_unit_fwd_prio_sel.sv
// One operand's forwarding path: the youngest producer writing the source register wins,
// otherwise the ID/EX register-file value passes through. x0 is never forwarded.
module fwd_prio_sel
    import operand_forward_unit_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int REG_AW  = 5,
    parameter int NUM_SRC = 2,
    localparam int SEL_W  = $clog2(NUM_SRC + 1)
) (
    input  logic [REG_AW-1:0]         i_rs,
    input  logic [XLEN-1:0]           i_rf_val,
    input  logic [NUM_SRC-1:0]        i_src_wen,
    input  logic [NUM_SRC*REG_AW-1:0] i_src_rd,
    input  logic [NUM_SRC*XLEN-1:0]   i_src_data,
    output logic [XLEN-1:0]           o_op,
    output logic [SEL_W-1:0]          o_sel
);

    // Scan oldest to youngest so the last hit written is the youngest producer.
    always_comb begin
        o_op  = i_rf_val;
        o_sel = SEL_W'(FWD_SEL_RF);
        if (i_rs != REG_AW'(REG_X0)) begin
            for (int i = NUM_SRC - 1; i >= 0; i--) begin
                if (i_src_wen[i] && (i_src_rd[i*REG_AW +: REG_AW] == i_rs)) begin
                    o_op  = i_src_data[i*XLEN +: XLEN];
                    o_sel = SEL_W'(i + 1);
                end
            end
        end
    end

endmodule

// File: rtl/operand_forward_unit.sv
// EX-stage operand forwarding plus load-use stall control for the pipelined RV32I core.
// Stall is asserted in the detect cycle and held for LOAD_LAT consecutive cycles.
module operand_forward_unit
    import operand_forward_unit_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int REG_AW   = 5,
    parameter int NUM_SRC  = 2,
    parameter int LOAD_LAT = 1,
    localparam int SEL_W   = $clog2(NUM_SRC + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REG_AW-1:0]         ex_rs1,
    input  logic [REG_AW-1:0]         ex_rs2,
    input  logic [XLEN-1:0]           ex_rs1_val,
    input  logic [XLEN-1:0]           ex_rs2_val,
    input  logic [NUM_SRC-1:0]        src_wen,
    input  logic [NUM_SRC*REG_AW-1:0] src_rd,
    input  logic [NUM_SRC*XLEN-1:0]   src_data,
    input  logic                      id_valid,
    input  logic [REG_AW-1:0]         id_rs1,
    input  logic [REG_AW-1:0]         id_rs2,
    input  logic                      ex_is_load,
    input  logic [REG_AW-1:0]         ex_rd,
    input  logic                      flush,
    output logic [XLEN-1:0]           op_a,
    output logic [XLEN-1:0]           op_b,
    output logic [SEL_W-1:0]          sel_a,
    output logic [SEL_W-1:0]          sel_b,
    output logic                      stall,
    output logic [31:0]               stall_cycles,
    output fsm_state_e                dbg_state
);

    localparam int CNT_W = $clog2(LOAD_LAT + 1);

    logic             w_hz;
    logic             w_stall;
    fsm_state_e       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_stall_cycles;

    fwd_prio_sel #(.XLEN(XLEN), .REG_AW(REG_AW), .NUM_SRC(NUM_SRC)) u_sel_a (
        .i_rs       (ex_rs1),
        .i_rf_val   (ex_rs1_val),
        .i_src_wen  (src_wen),
        .i_src_rd   (src_rd),
        .i_src_data (src_data),
        .o_op       (op_a),
        .o_sel      (sel_a)
    );

    fwd_prio_sel #(.XLEN(XLEN), .REG_AW(REG_AW), .NUM_SRC(NUM_SRC)) u_sel_b (
        .i_rs       (ex_rs2),
        .i_rf_val   (ex_rs2_val),
        .i_src_wen  (src_wen),
        .i_src_rd   (src_rd),
        .i_src_data (src_data),
        .o_op       (op_b),
        .o_sel      (sel_b)
    );

    assign w_hz = id_valid & ex_is_load & (ex_rd != REG_AW'(REG_X0)) &
                  ((ex_rd == id_rs1) | (ex_rd == id_rs2));

    // Flush and reset both win over a pending or newly detected hazard in the same cycle.
    always_comb begin
        w_stall = 1'b0;
        if (!rst && !flush) begin
            w_stall = (r_state == ST_HOLD) ? 1'b1 : w_hz;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_hz && (LOAD_LAT > 1)) begin
                        r_state <= ST_HOLD;
                        r_cnt   <= CNT_W'(LOAD_LAT - 1);
                    end
                end
                ST_HOLD: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
        end else if (w_stall && (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign stall        = w_stall;
    assign stall_cycles = r_stall_cycles;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_operand_forward_unit.sv
// Scoreboard bench for operand_forward_unit (LOAD_LAT=3, two forwarding sources):
// the driver pushes reference-model expectations, a negedge monitor pops and compares.
module tb_operand_forward_unit;
    import operand_forward_unit_pkg::*;

    localparam int XLEN     = 32;
    localparam int REG_AW   = 5;
    localparam int NUM_SRC  = 2;
    localparam int LOAD_LAT = 3;
    localparam int SEL_W    = $clog2(NUM_SRC + 1);

    typedef struct packed {
        logic [XLEN-1:0]  op_a;
        logic [XLEN-1:0]  op_b;
        logic [SEL_W-1:0] sel_a;
        logic [SEL_W-1:0] sel_b;
        logic             stall;
        logic [31:0]      cyc;
        logic             hold;
    } exp_t;
    localparam int W = $bits(exp_t);

    logic                      clk = 1'b0;
    logic                      rst;
    logic [REG_AW-1:0]         ex_rs1, ex_rs2, id_rs1, id_rs2, ex_rd;
    logic [XLEN-1:0]           ex_rs1_val, ex_rs2_val;
    logic [NUM_SRC-1:0]        src_wen;
    logic [NUM_SRC*REG_AW-1:0] src_rd;
    logic [NUM_SRC*XLEN-1:0]   src_data;
    logic                      id_valid, ex_is_load, flush;
    logic [XLEN-1:0]           op_a, op_b;
    logic [SEL_W-1:0]          sel_a, sel_b;
    logic                      stall;
    logic [31:0]               stall_cycles;
    fsm_state_e                dbg_state;

    logic [W-1:0] exp_q[$];
    int           n_cmp = 0;
    int           n_err = 0;
    int           stall_left = 0;
    longint       cnt_model = 0;

    // clock / reset
    always #5 clk = ~clk;

    operand_forward_unit #(
        .XLEN(XLEN), .REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .LOAD_LAT(LOAD_LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val),
        .src_wen(src_wen), .src_rd(src_rd), .src_data(src_data),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .ex_is_load(ex_is_load), .ex_rd(ex_rd), .flush(flush),
        .op_a(op_a), .op_b(op_b), .sel_a(sel_a), .sel_b(sel_b),
        .stall(stall), .stall_cycles(stall_cycles), .dbg_state(dbg_state)
    );

    // reference model: first producer (youngest) naming the register supplies the value
    task automatic fwd_model(input logic [REG_AW-1:0] rs, input logic [XLEN-1:0] rf,
                             output logic [XLEN-1:0] op, output logic [SEL_W-1:0] sel);
        logic [REG_AW-1:0] rd_arr[NUM_SRC];
        logic [XLEN-1:0]   dat_arr[NUM_SRC];
        bit                found = 0;
        for (int i = 0; i < NUM_SRC; i++) begin
            rd_arr[i]  = src_rd[i*REG_AW +: REG_AW];
            dat_arr[i] = src_data[i*XLEN +: XLEN];
        end
        op  = rf;
        sel = '0;
        if (rs != 0) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (!found && src_wen[i] && rd_arr[i] == rs) begin
                    op    = dat_arr[i];
                    sel   = SEL_W'(i + 1);
                    found = 1;
                end
            end
        end
    endtask

    // driver: compute this cycle's expectation, push it, advance one clock
    task automatic step();
        exp_t             e;
        logic [XLEN-1:0]  oa, ob;
        logic [SEL_W-1:0] sa, sb;
        bit               hz;
        fwd_model(ex_rs1, ex_rs1_val, oa, sa);
        fwd_model(ex_rs2, ex_rs2_val, ob, sb);
        e.op_a  = oa;
        e.op_b  = ob;
        e.sel_a = sa;
        e.sel_b = sb;
        e.cyc   = cnt_model[31:0];
        e.hold  = (stall_left > 0);
        hz = id_valid && ex_is_load && ex_rd != 0 && (ex_rd == id_rs1 || ex_rd == id_rs2);
        if (rst || flush) begin
            e.stall    = 1'b0;
            stall_left = 0;
        end else if (stall_left > 0) begin
            e.stall    = 1'b1;
            stall_left = stall_left - 1;
        end else if (hz) begin
            e.stall    = 1'b1;
            stall_left = LOAD_LAT - 1;
        end else begin
            e.stall    = 1'b0;
        end
        exp_q.push_back(e);
        if (rst) cnt_model = 0;
        else if (e.stall && cnt_model < 64'hFFFF_FFFF) cnt_model = cnt_model + 1;
        @(posedge clk);
        #2;
    endtask

    task automatic quiet();
        rst        = 1'b0;
        flush      = 1'b0;
        src_wen    = '0;
        src_rd     = '0;
        src_data   = {$urandom, $urandom};
        ex_rs1     = 5'd1;
        ex_rs2     = 5'd2;
        ex_rs1_val = $urandom;
        ex_rs2_val = $urandom;
        id_valid   = 1'b0;
        id_rs1     = '0;
        id_rs2     = '0;
        ex_is_load = 1'b0;
        ex_rd      = '0;
    endtask

    task automatic set_hazard(input logic [REG_AW-1:0] rd);
        ex_is_load = 1'b1;
        ex_rd      = rd;
        id_rs2     = rd;
        id_rs1     = 5'd9;
        id_valid   = 1'b1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("op_a", op_a, e.op_a);
            chk("op_b", op_b, e.op_b);
            chk("sel_a", 32'(sel_a), 32'(e.sel_a));
            chk("sel_b", 32'(sel_b), 32'(e.sel_b));
            chk("stall", 32'(stall), 32'(e.stall));
            chk("stall_cycles", stall_cycles, e.cyc);
            chk("fsm_hold", 32'(dbg_state == ST_HOLD), 32'(e.hold));
        end
    end

    initial begin
        quiet();
        rst = 1'b1;
        @(posedge clk);
        #2;
        // reset state; a live hazard must not stall while rst is high
        set_hazard(5'd4);
        step();
        step();
        quiet();

        // youngest producer wins
        src_wen  = 2'b11;
        src_rd   = {5'd5, 5'd5};
        src_data = {32'h0000_BBBB, 32'h0000_AAAA};
        ex_rs1   = 5'd5;
        step();
        // x0 is never forwarded
        quiet();
        src_wen    = 2'b01;
        src_rd     = {5'd3, 5'd0};
        src_data   = {32'h0000_9999, 32'h0000_1234};
        ex_rs2     = 5'd0;
        ex_rs2_val = '0;
        step();
        // only MEM/WB matches, both operands pick it; then no writers
        quiet();
        src_wen  = 2'b10;
        src_rd   = {5'd7, 5'd2};
        src_data = {32'h0000_0055, 32'h0000_0011};
        ex_rs1   = 5'd7;
        ex_rs2   = 5'd7;
        step();
        src_wen = 2'b00;
        step();

        // load-use: three stall cycles, then released
        quiet();
        set_hazard(5'd3);
        step();
        step();
        step();
        quiet();
        step();
        set_hazard(5'd3);
        id_valid = 1'b0;
        step();
        set_hazard(5'd0);
        step();

        // flush in the second stall cycle, then flush coincident with a hazard
        quiet();
        set_hazard(5'd6);
        step();
        flush = 1'b1;
        step();
        quiet();
        step();
        set_hazard(5'd6);
        flush = 1'b1;
        step();

        // reset mid-HOLD, then counter saturation
        quiet();
        set_hazard(5'd8);
        step();
        rst = 1'b1;
        step();
        quiet();
        step();
        dut.r_stall_cycles = 32'hFFFF_FFFE;
        cnt_model          = 64'hFFFF_FFFE;
        set_hazard(5'd8);
        step();
        step();
        step();
        quiet();
        step();
        step();

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            rst        = ($urandom_range(0, 49) == 0);
            flush      = ($urandom_range(0, 9) == 0);
            src_wen    = NUM_SRC'($urandom_range(0, 3));
            src_rd     = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            src_data   = {$urandom, $urandom};
            ex_rs1     = 5'($urandom_range(0, 7));
            ex_rs2     = 5'($urandom_range(0, 7));
            ex_rs1_val = $urandom;
            ex_rs2_val = $urandom;
            id_valid   = ($urandom_range(0, 3) != 0);
            ex_is_load = ($urandom_range(0, 1) == 1);
            ex_rd      = 5'($urandom_range(0, 3));
            id_rs1     = 5'($urandom_range(0, 3));
            id_rs2     = 5'($urandom_range(0, 3));
            step();
        end
        quiet();
        step();

        begin
            int budget = 20;
            while (exp_q.size() > 0 && budget > 0) begin
                @(posedge clk);
                budget--;
            end
            if (exp_q.size() > 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL drain: got %0d pending expected 0", exp_q.size());
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
